// File: rtl/nw_pkg.sv
// Shared types and helpers for the network router output path.
package nw_pkg;

   localparam int unsigned PORT_W = 3;

   typedef struct packed {
      logic              head;
      logic              tail;
      logic [PORT_W-1:0] output_port;
   } flit_ctrl_t;

   typedef enum logic [0:0] {
      StIdle,
      StLocked
   } arb_state_e;

   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/nw_rr_pick.sv
// Combinational round-robin picker: first set request at or after the start pointer.
module nw_rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0] idx_o,
   output logic             found_o
);

   logic [31:0]      sum;
   logic [PTR_W-1:0] j;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      found_o = 1'b0;
      sum     = '0;
      j       = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         sum = 32'(ptr_i) + k;
         j   = PTR_W'(sum % N_REQ);
         if (!found_o && req_i[j]) begin
            found_o  = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = j;
         end
      end
   end

endmodule

// File: rtl/nw_output_arbiter.sv
// Wormhole output-port arbiter: round-robin among head flits, winner holds the
// port until its tail is pushed into the shared output register.
module nw_output_arbiter
   import nw_pkg::*;
#(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned PTR_W  = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_head,
   input  logic [N_REQ-1:0]        req_tail,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_pop,
   input  logic                    out_ready,
   output logic                    out_push,
   output logic [DATA_W-1:0]       out_data,
   output logic                    locked,
   output logic                    proto_err
);

   arb_state_e       st_q;
   logic [PTR_W-1:0] rr_ptr_q;
   logic [PTR_W-1:0] owner_q;
   logic             proto_err_q;

   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] pick_gnt;
   logic [N_REQ-1:0] owner_oh;
   logic [PTR_W-1:0] pick_idx;
   logic [PTR_W-1:0] sel_idx;
   logic             pick_found;
   logic             grant;
   logic             err_set;

   assign elig = req_valid & req_head;

   nw_rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req_i   (elig),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   always_comb begin
      owner_oh          = '0;
      owner_oh[owner_q] = 1'b1;
      grant             = 1'b0;
      err_set           = 1'b0;
      sel_idx           = pick_idx;
      if (st_q == StIdle) begin
         grant   = out_ready & pick_found;
         // A body/tail flit with no packet in flight means upstream lost framing.
         err_set = out_ready & ~pick_found & (|(req_valid & ~req_head));
      end else begin
         sel_idx = owner_q;
         grant   = out_ready & req_valid[owner_q] & ~req_head[owner_q];
         err_set = out_ready & req_valid[owner_q] & req_head[owner_q];
      end
      if (!rst_n) begin
         grant = 1'b0;
      end
      req_pop = '0;
      if (grant) begin
         req_pop = (st_q == StIdle) ? pick_gnt : owner_oh;
      end
      out_push = grant;
      out_data = req_data[DATA_W-1:0];
      if (grant) begin
         out_data = req_data[sel_idx*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q        <= StIdle;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         proto_err_q <= 1'b0;
      end else begin
         if (err_set) begin
            proto_err_q <= 1'b1;
         end
         if (grant) begin
            if (req_tail[sel_idx]) begin
               st_q     <= StIdle;
               rr_ptr_q <= PTR_W'(rr_next(32'(sel_idx), N_REQ));
            end else begin
               st_q    <= StLocked;
               owner_q <= sel_idx;
            end
         end
      end
   end

   assign locked    = (st_q == StLocked);
   assign proto_err = proto_err_q;

   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_pop));
   assert property (@(posedge clk) disable iff (!rst_n) out_push |-> out_ready);

endmodule

// File: tb/tb_nw_output_arbiter.sv
// Directed bench for nw_output_arbiter: round-robin, wormhole locking, stalls,
// protocol errors and reset behaviour.
module tb_nw_output_arbiter;

   localparam int unsigned N = 4;
   localparam int unsigned W = 32;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_head;
   logic [N-1:0]   req_tail;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_pop;
   logic           out_ready;
   logic           out_push;
   logic [W-1:0]   out_data;
   logic           locked;
   logic           proto_err;

   int pass_cnt;
   int total_cnt;

   nw_output_arbiter #(
      .N_REQ  (N),
      .DATA_W (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_head  (req_head),
      .req_tail  (req_tail),
      .req_data  (req_data),
      .req_pop   (req_pop),
      .out_ready (out_ready),
      .out_push  (out_push),
      .out_data  (out_data),
      .locked    (locked),
      .proto_err (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] port_data(input int i);
      return 32'hDA7A_0000 + 32'(i) * 32'h111;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] h, input logic [N-1:0] t,
                        input logic rdy);
      req_valid = v;
      req_head  = h;
      req_tail  = t;
      out_ready = rdy;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(4'b1111, 4'b1111, 4'b1111, 1'b1);
      total_cnt++;
      if (req_pop !== 4'b0000 || out_push !== 1'b0)
         $display("FAIL reset_pop: pop=%b push=%b, want 0000/0", req_pop, out_push);
      else pass_cnt++;
      step();
      total_cnt++;
      if (locked !== 1'b0 || proto_err !== 1'b0)
         $display("FAIL reset_state: locked=%b perr=%b, want 0/0", locked, proto_err);
      else pass_cnt++;
      rst_n = 1'b1;
      drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
      step();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp;
      drive(4'b1111, 4'b1111, 4'b1111, 1'b1);
      for (int k = 0; k < 8; k++) begin
         exp = 4'b0001 << (k % 4);
         total_cnt++;
         if (req_pop !== exp || out_push !== 1'b1 || out_data !== port_data(k % 4) ||
             locked !== 1'b0)
            $display("FAIL rr_grant[%0d]: pop=%b push=%b data=%h locked=%b, want %b/1/%h/0",
                     k, req_pop, out_push, out_data, locked, exp, port_data(k % 4));
         else pass_cnt++;
         step();
      end
   endtask

   task automatic test_wormhole();
      // Port 2 head alone, then port 0 head+tail competes during 2's body/tail.
      drive(4'b0100, 4'b0100, 4'b0000, 1'b1);
      total_cnt++;
      if (req_pop !== 4'b0100 || locked !== 1'b0 || out_data !== port_data(2))
         $display("FAIL worm_head: pop=%b locked=%b data=%h, want 0100/0/%h",
                  req_pop, locked, out_data, port_data(2));
      else pass_cnt++;
      step();
      drive(4'b0101, 4'b0001, 4'b0001, 1'b1);
      total_cnt++;
      if (req_pop !== 4'b0100 || locked !== 1'b1)
         $display("FAIL worm_body: pop=%b locked=%b, want 0100/1", req_pop, locked);
      else pass_cnt++;
      step();
      drive(4'b0101, 4'b0001, 4'b0101, 1'b1);
      total_cnt++;
      if (req_pop !== 4'b0100 || locked !== 1'b1)
         $display("FAIL worm_tail: pop=%b locked=%b, want 0100/1", req_pop, locked);
      else pass_cnt++;
      step();
      drive(4'b0001, 4'b0001, 4'b0001, 1'b1);
      total_cnt++;
      if (req_pop !== 4'b0001 || locked !== 1'b0 || out_data !== port_data(0))
         $display("FAIL worm_next: pop=%b locked=%b data=%h, want 0001/0/%h",
                  req_pop, locked, out_data, port_data(0));
      else pass_cnt++;
      step();
   endtask

   task automatic test_bubble();
      // rr_ptr is 1 here; port 1 takes the port with a head flit.
      drive(4'b0010, 4'b0010, 4'b0000, 1'b1);
      total_cnt++;
      if (req_pop !== 4'b0010)
         $display("FAIL bubble_lock: pop=%b, want 0010", req_pop);
      else pass_cnt++;
      step();
      for (int k = 0; k < 3; k++) begin
         drive(4'b1000, 4'b1000, 4'b1000, 1'b1);
         total_cnt++;
         if (req_pop !== 4'b0000 || out_push !== 1'b0 || locked !== 1'b1)
            $display("FAIL bubble_wait[%0d]: pop=%b push=%b locked=%b, want 0000/0/1",
                     k, req_pop, out_push, locked);
         else pass_cnt++;
         step();
      end
      drive(4'b1010, 4'b1000, 4'b1010, 1'b1);
      total_cnt++;
      if (req_pop !== 4'b0010 || out_data !== port_data(1))
         $display("FAIL bubble_tail: pop=%b data=%h, want 0010/%h", req_pop, out_data,
                  port_data(1));
      else pass_cnt++;
      step();
      drive(4'b1000, 4'b1000, 4'b1000, 1'b1);
      total_cnt++;
      if (req_pop !== 4'b1000 || locked !== 1'b0)
         $display("FAIL bubble_after: pop=%b locked=%b, want 1000/0", req_pop, locked);
      else pass_cnt++;
      step();
   endtask

   task automatic test_stall();
      // rr_ptr wrapped to 0 after port 3's single-flit packet.
      for (int k = 0; k < 4; k++) begin
         drive(4'b1111, 4'b1111, 4'b1111, 1'b0);
         total_cnt++;
         if (req_pop !== 4'b0000 || out_push !== 1'b0 || out_data !== port_data(0) ||
             locked !== 1'b0)
            $display("FAIL stall[%0d]: pop=%b push=%b data=%h locked=%b, want 0000/0/%h/0",
                     k, req_pop, out_push, out_data, locked, port_data(0));
         else pass_cnt++;
         step();
      end
      drive(4'b1111, 4'b1111, 4'b1111, 1'b1);
      total_cnt++;
      if (req_pop !== 4'b0001 || out_push !== 1'b1)
         $display("FAIL stall_resume: pop=%b push=%b, want 0001/1", req_pop, out_push);
      else pass_cnt++;
      step();
   endtask

   task automatic test_proto_err_idle();
      drive(4'b0010, 4'b0000, 4'b0000, 1'b1);
      total_cnt++;
      if (req_pop !== 4'b0000 || out_push !== 1'b0)
         $display("FAIL perr_nogrant: pop=%b push=%b, want 0000/0", req_pop, out_push);
      else pass_cnt++;
      step();
      drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
      step();
      step();
      total_cnt++;
      if (proto_err !== 1'b1 || locked !== 1'b0)
         $display("FAIL perr_sticky: perr=%b locked=%b, want 1/0", proto_err, locked);
      else pass_cnt++;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      total_cnt++;
      if (proto_err !== 1'b0)
         $display("FAIL perr_clear: perr=%b, want 0", proto_err);
      else pass_cnt++;
   endtask

   task automatic test_proto_err_locked();
      drive(4'b0010, 4'b0010, 4'b0000, 1'b1);
      step();
      drive(4'b0010, 4'b0010, 4'b0010, 1'b1);
      total_cnt++;
      if (req_pop !== 4'b0000 || out_push !== 1'b0)
         $display("FAIL lkhead_nogrant: pop=%b push=%b, want 0000/0", req_pop, out_push);
      else pass_cnt++;
      step();
      total_cnt++;
      if (proto_err !== 1'b1 || locked !== 1'b1)
         $display("FAIL lkhead_err: perr=%b locked=%b, want 1/1", proto_err, locked);
      else pass_cnt++;
      drive(4'b0010, 4'b0000, 4'b0010, 1'b1);
      total_cnt++;
      if (req_pop !== 4'b0010)
         $display("FAIL lkhead_tail: pop=%b, want 0010", req_pop);
      else pass_cnt++;
      step();
   endtask

   task automatic test_reset_locked();
      // rr_ptr is 2; port 3 is the only eligible head.
      drive(4'b1000, 4'b1000, 4'b0000, 1'b1);
      total_cnt++;
      if (req_pop !== 4'b1000)
         $display("FAIL rstlk_lock: pop=%b, want 1000", req_pop);
      else pass_cnt++;
      step();
      rst_n = 1'b0;
      drive(4'b1111, 4'b1111, 4'b1111, 1'b1);
      total_cnt++;
      if (req_pop !== 4'b0000 || out_push !== 1'b0 || locked !== 1'b1)
         $display("FAIL rstlk_hold: pop=%b push=%b locked=%b, want 0000/0/1",
                  req_pop, out_push, locked);
      else pass_cnt++;
      step();
      rst_n = 1'b1;
      #1;
      total_cnt++;
      if (locked !== 1'b0 || proto_err !== 1'b0 || req_pop !== 4'b0001)
         $display("FAIL rstlk_after: locked=%b perr=%b pop=%b, want 0/0/0001",
                  locked, proto_err, req_pop);
      else pass_cnt++;
      step();
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      rst_n     = 1'b0;
      req_valid = '0;
      req_head  = '0;
      req_tail  = '0;
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = port_data(i);
      step();
      test_reset();
      test_round_robin();
      test_wormhole();
      test_bubble();
      test_stall();
      test_proto_err_idle();
      test_proto_err_locked();
      test_reset_locked();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
